// File: rtl/alu_pkg.sv
// Shared ALU types: default result width, opcode encoding and the result entry
// captured by the downstream result buffer.
package alu_pkg;

  localparam int DATA_W = 6;

  typedef enum logic [1:0] {
    OP_ADD        = 2'b00,
    OP_OR_XOR_AND = 2'b01,
    OP_SUB        = 2'b10,
    OP_SHIFT      = 2'b11
  } op_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              flag;
    op_t               op;
  } result_entry_t;

endpackage

// File: rtl/alu_result_fifo_mem.sv
// DEPTH-entry result storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the owning FIFO never reads an unwritten slot as valid.
module alu_result_fifo_mem
  import alu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = result_entry_t
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// Result FIFO behind the ALU: non-stalling writer, valid/ready reader, sticky overflow.
// Optional ALU_RESULT_STATS_EN adds saturating accepted / flagged push counters.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int DEPTH  = 4
`ifdef ALU_RESULT_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_flag,
  input  logic [1:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic                     out_flag,
  output logic [1:0]               out_op,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     clr_ovf
`ifdef ALU_RESULT_STATS_EN
  ,
  output logic [STAT_W-1:0]        stat_total,
  output logic [STAT_W-1:0]        stat_flagged
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              flag;
    op_t               op;
  } entry_t;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             full_q, empty_q, ovf_q;
  logic             push, pop, drop;
  entry_t           wdata, rdata;

  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign pop  = !empty_q && out_ready;
  assign push = in_valid && (!full_q || pop);
  assign drop = in_valid && full_q && !pop;

  assign wdata = '{result: in_result, flag: in_flag, op: op_t'(in_op)};

  always_comb begin
    cnt_nxt = cnt_q;
    if (push && !pop)      cnt_nxt = cnt_q + 1'b1;
    else if (pop && !push) cnt_nxt = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt_q   <= cnt_nxt;
      full_q  <= (cnt_nxt == FULL_CNT);
      empty_q <= (cnt_nxt == '0);
      // A drop wins over a simultaneous clear so no loss goes unreported.
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  alu_result_fifo_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign out_valid  = !empty_q;
  assign out_result = empty_q ? '0   : rdata.result;
  assign out_flag   = empty_q ? 1'b0 : rdata.flag;
  assign out_op     = empty_q ? 2'b00 : rdata.op;
  assign count      = cnt_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign overflow   = ovf_q;

`ifdef ALU_RESULT_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_total   <= '0;
      stat_flagged <= '0;
    end else if (push) begin
      if (stat_total != '1)              stat_total   <= stat_total + 1'b1;
      if (in_flag && stat_flagged != '1) stat_flagged <= stat_flagged + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed + random scoreboard bench for alu_result_buffer (DEPTH=4, DATA_W=6).
module tb_alu_result_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_flag, out_ready, clr_ovf;
  logic [5:0] in_result;
  logic [1:0] in_op;
  logic       out_valid, out_flag, full, empty, overflow;
  logic [5:0] out_result;
  logic [1:0] out_op;
  logic [2:0] count;
`ifdef ALU_RESULT_STATS_EN
  logic [15:0] stat_total, stat_flagged;
  int          m_total, m_flagged;
`endif

  always #5 clk = ~clk;

  alu_result_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_result  (in_result),
    .in_flag    (in_flag),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flag   (out_flag),
    .out_op     (out_op),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
`ifdef ALU_RESULT_STATS_EN
    ,
    .stat_total   (stat_total),
    .stat_flagged (stat_flagged)
`endif
  );

  typedef struct {
    logic [5:0] r;
    logic       f;
    logic [1:0] o;
  } ent_t;

  ent_t q[$];
  logic movf;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs depend only on registered state, so they are checked at the negedge.
  task automatic check_state();
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("count", {29'd0, count}, q.size());
    chk("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
    chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
    chk("overflow", {31'd0, overflow}, {31'd0, movf});
    if (q.size() != 0) begin
      chk("out_result", {26'd0, out_result}, {26'd0, q[0].r});
      chk("out_flag", {31'd0, out_flag}, {31'd0, q[0].f});
      chk("out_op", {30'd0, out_op}, {30'd0, q[0].o});
    end else begin
      chk("out_result_zero", {26'd0, out_result}, 32'd0);
      chk("out_flag_zero", {31'd0, out_flag}, 32'd0);
      chk("out_op_zero", {30'd0, out_op}, 32'd0);
    end
  endtask

  // One clock: drive at negedge, check current state, advance the model.
  task automatic cycle(input logic iv, input logic [5:0] r, input logic f,
                       input logic [1:0] o, input logic rdy, input logic clr);
    ent_t e;
    logic pop_m, push_m, drop_m;
    @(negedge clk);
    in_valid = iv; in_result = r; in_flag = f; in_op = o;
    out_ready = rdy; clr_ovf = clr;
    check_state();
    pop_m  = (q.size() != 0) && rdy;
    push_m = iv && ((q.size() < DEPTH) || pop_m);
    drop_m = iv && !push_m;
    if (pop_m) void'(q.pop_front());
    if (push_m) begin
      e.r = r; e.f = f; e.o = o;
      q.push_back(e);
`ifdef ALU_RESULT_STATS_EN
      m_total++;
      if (f) m_flagged++;
`endif
    end
    if (drop_m)   movf = 1'b1;
    else if (clr) movf = 1'b0;
  endtask

  task automatic push(input logic [5:0] r, input logic [1:0] o, input logic rdy);
    cycle(1'b1, r, r != 6'd0, o, rdy, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 6'd0, 1'b0, 2'b00, rdy, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 0; in_result = 0; in_flag = 0; in_op = 0; out_ready = 0; clr_ovf = 0;
    movf = 1'b0;
`ifdef ALU_RESULT_STATS_EN
    m_total = 0; m_flagged = 0;
`endif
    #12;
    check_state();
    @(negedge clk);
    reset = 1'b1;

    // 1: single push visible next cycle
    push(6'd8, 2'b00, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // 2: fill, drop on full, drain in order, clear overflow
    push(6'd8, 2'b01, 1'b0);
    push(6'd0, 2'b10, 1'b0);
    push(6'd13, 2'b11, 1'b0);
    push(6'd5, 2'b00, 1'b0);
    push(6'd7, 2'b01, 1'b0);
    idle(1'b0);
    repeat (4) idle(1'b1);
    cycle(1'b0, 6'd0, 1'b0, 2'b00, 1'b0, 1'b1);
    idle(1'b0);

    // drop and clear in the same cycle keep overflow set
    repeat (4) push(6'd3, 2'b10, 1'b0);
    cycle(1'b1, 6'd21, 1'b1, 2'b01, 1'b0, 1'b1);
    idle(1'b0);
    repeat (4) idle(1'b1);
    cycle(1'b0, 6'd0, 1'b0, 2'b00, 1'b0, 1'b1);

    // 3: full with simultaneous push and pop
    push(6'd1, 2'b00, 1'b0);
    push(6'd2, 2'b01, 1'b0);
    push(6'd3, 2'b10, 1'b0);
    push(6'd4, 2'b11, 1'b0);
    push(6'd9, 2'b01, 1'b1);
    idle(1'b0);
    repeat (4) idle(1'b1);

    // 4: empty with ready asserted, then confirm pointers still line up
    repeat (3) idle(1'b1);
    push(6'd42, 2'b11, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // 5: asynchronous reset mid-cycle with 3 entries held
    push(6'd11, 2'b00, 1'b0);
    push(6'd12, 2'b01, 1'b0);
    push(6'd14, 2'b10, 1'b0);
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    check_state();
    @(posedge clk);
    #2 reset = 1'b0;
    q.delete();
    movf = 1'b0;
`ifdef ALU_RESULT_STATS_EN
    m_total = 0; m_flagged = 0;
`endif
    #1 check_state();
    @(negedge clk);
    reset = 1'b1;
    push(6'd30, 2'b11, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // 6: flag counting with one drop
    cycle(1'b1, 6'd1, 1'b1, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 6'd2, 1'b0, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 6'd3, 1'b1, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 6'd4, 1'b0, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 6'd5, 1'b1, 2'b00, 1'b0, 1'b0);
    idle(1'b0);
`ifdef ALU_RESULT_STATS_EN
    chk("stat_total", {16'd0, stat_total}, m_total);
    chk("stat_flagged", {16'd0, stat_flagged}, m_flagged);
`endif
    repeat (4) idle(1'b1);
    cycle(1'b0, 6'd0, 1'b0, 2'b00, 1'b0, 1'b1);

    // random traffic against the scoreboard
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom), 2'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));
    end
    idle(1'b0);
`ifdef ALU_RESULT_STATS_EN
    chk("stat_total_end", {16'd0, stat_total}, m_total);
    chk("stat_flagged_end", {16'd0, stat_flagged}, m_flagged);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
